// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-lane data memory and its load-extension unit.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        ACK  = 2'b10
    } state_t;

    function automatic int addr_bits(input int depth_bytes);
        return $clog2(depth_bytes);
    endfunction

    // Reserved size behaves as a word wherever it is not trapped.
    function automatic logic [2:0] size_bytes(input mem_size_t size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lsb);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lsb[0];
            SZ_WORD: return addr_lsb != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Combinational load extension: picks byte/half/word from four raw little-endian bytes
// and sign- or zero-extends to 32 bits. Also used by the pipeline forwarding path.
module dmem_load_extend
    import dmem_pkg::*;
(
    input  mem_size_t   i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_raw,
    output logic [31:0] o_data
);

    logic w_fill_b;
    logic w_fill_h;

    assign w_fill_b = !i_unsigned && i_raw[7];
    assign w_fill_h = !i_unsigned && i_raw[15];

    // NOTE: o_data gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        o_data = i_raw;
        case (i_size)
            SZ_BYTE: o_data = {{24{w_fill_b}}, i_raw[7:0]};
            SZ_HALF: o_data = {{16{w_fill_h}}, i_raw[15:0]};
            default: o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/byte_lane_data_memory.sv
// Byte-addressed little-endian data memory with req/ready/ack handshake and configurable latency.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned and reserved-size accesses via err_o.
module byte_lane_data_memory
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    output logic              ready_o,
    output logic              ack_o,
    output logic [31:0]       rdata_o,
    output logic              err_o
);

    localparam int AW = addr_bits(DEPTH_BYTES);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_rdata;

    logic            r_we;
    mem_size_t       r_size;
    logic            r_unsigned;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_data;

    logic [7:0]      r_mem [DEPTH_BYTES];

    logic            w_in_idle;
    logic            w_enter_ack;
    logic [AW-1:0]   w_src_addr;
    mem_size_t       w_src_size;
    logic            w_src_uns;
    logic            w_src_we;
    logic            w_src_fault;
    logic            w_ack_fault;
    logic            w_wr_en;
    logic [31:0]     w_raw;
    logic [31:0]     w_ext;

    function automatic logic [AW-1:0] lane_addr(input logic [AW-1:0] base, input int k);
        return base + AW'(k);
    endfunction

    generate
        if (ADDR_W > AW) begin : g_addr_wrap
            logic w_unused_addr_bits;
            assign w_unused_addr_bits = ^addr_i[ADDR_W-1:AW];
        end
    endgenerate

    // With LATENCY=1 the read happens on the accept edge, so the live inputs feed the read path.
    assign w_in_idle   = (r_state == IDLE);
    assign w_src_addr  = w_in_idle ? addr_i[AW-1:0] : r_addr;
    assign w_src_size  = w_in_idle ? mem_size_t'(size_i) : r_size;
    assign w_src_uns   = w_in_idle ? unsigned_i : r_unsigned;
    assign w_src_we    = w_in_idle ? we_i : r_we;
    assign w_enter_ack = w_in_idle ? (req_i && (LATENCY == 1))
                                   : ((r_state == BUSY) && (r_count == '0));

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_src_fault = is_misaligned(w_src_size, w_src_addr[1:0]);
    assign w_ack_fault = is_misaligned(r_size, r_addr[1:0]);
`else
    assign w_src_fault = 1'b0;
    assign w_ack_fault = 1'b0;
`endif

    assign ready_o = w_in_idle;
    assign ack_o   = (r_state == ACK);
    assign err_o   = ack_o && w_ack_fault;
    assign rdata_o = r_rdata;
    assign w_wr_en = ack_o && r_we && !w_ack_fault && !rst_i;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_raw[8*k +: 8] = r_mem[lane_addr(w_src_addr, k)];
        end
    end

    dmem_load_extend u_load_extend (
        .i_size     (w_src_size),
        .i_unsigned (w_src_uns),
        .i_raw      (w_raw),
        .o_data     (w_ext)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_count <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_i) begin
                        if (LATENCY == 1) begin
                            r_state <= ACK;
                        end else begin
                            r_state <= BUSY;
                            r_count <= CW'(LATENCY - 2);
                        end
                    end
                end
                BUSY: begin
                    if (r_count == '0) r_state <= ACK;
                    else               r_count <= r_count - CW'(1);
                end
                ACK:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (w_enter_ack && (!w_src_we || w_src_fault)) begin
                r_rdata <= w_src_fault ? '0 : w_ext;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (ready_o && req_i) begin
            r_we       <= we_i;
            r_size     <= mem_size_t'(size_i);
            r_unsigned <= unsigned_i;
            r_addr     <= addr_i[AW-1:0];
            r_data     <= data_i;
        end
    end

    // NOTE: the storage array is deliberately not reset; contents are undefined until written.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < size_bytes(r_size)) begin
                    r_mem[lane_addr(r_addr, k)] <= r_data[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_byte_lane_data_memory.sv
// Bench for byte_lane_data_memory: three instances (LATENCY 1, LATENCY 4, 64-byte depth),
// directed vector table, hand sequences for handshake/reset corners, randomized ops vs. a byte-array model.
module tb_byte_lane_data_memory;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst   [3];
    logic        req   [3];
    logic        we    [3];
    logic [1:0]  sz    [3];
    logic        uns   [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic        ready [3];
    logic        ack   [3];
    logic [31:0] rdata [3];
    logic        err   [3];

    logic [7:0]  mm [3][1024];
    logic [31:0] m_rdata [3];

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    byte_lane_data_memory #(.DEPTH_BYTES(1024), .LATENCY(1), .ADDR_W(32)) u_dut_l1 (
        .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .we_i(we[0]), .size_i(sz[0]),
        .unsigned_i(uns[0]), .addr_i(addr[0]), .data_i(wdata[0]), .ready_o(ready[0]),
        .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0]));

    byte_lane_data_memory #(.DEPTH_BYTES(1024), .LATENCY(4), .ADDR_W(32)) u_dut_l4 (
        .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .we_i(we[1]), .size_i(sz[1]),
        .unsigned_i(uns[1]), .addr_i(addr[1]), .data_i(wdata[1]), .ready_o(ready[1]),
        .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1]));

    byte_lane_data_memory #(.DEPTH_BYTES(64), .LATENCY(2), .ADDR_W(32)) u_dut_small (
        .clk_i(clk), .rst_i(rst[2]), .req_i(req[2]), .we_i(we[2]), .size_i(sz[2]),
        .unsigned_i(uns[2]), .addr_i(addr[2]), .data_i(wdata[2]), .ready_o(ready[2]),
        .ack_o(ack[2]), .rdata_o(rdata[2]), .err_o(err[2]));

    function automatic int depth_of(input int d);
        return (d == 2) ? 64 : 1024;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 4 : 2);
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : ((s == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic model_fault(input logic [1:0] s, input logic [31:0] a);
        logic mis;
        mis = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
        return mis && TRAP_EN;
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [1:0] s, input logic u,
                                               input logic [31:0] a);
        logic [31:0] v;
        int unsigned idx;
        int n;
        n = nbytes(s);
        v = 32'h0;
        for (int k = 0; k < n; k++) begin
            idx = (a + 32'(k)) % 32'(depth_of(d));
            v = v | (32'(mm[d][idx]) << (8 * k));
        end
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic model_store(input int d, input logic [1:0] s, input logic [31:0] a,
                               input logic [31:0] dt);
        int unsigned idx;
        for (int k = 0; k < nbytes(s); k++) begin
            idx = (a + 32'(k)) % 32'(depth_of(d));
            mm[d][idx] = dt[8*k +: 8];
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic op(input int d, input logic w, input logic [1:0] s, input logic u,
                      input logic [31:0] a, input logic [31:0] dt,
                      output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; sz[d] = s; uns[d] = u; addr[d] = a; wdata[d] = dt;
        @(posedge clk);
        #1 req[d] = 1'b0;
        for (lat = 1; lat <= 50; lat++) begin
            @(negedge clk);
            if (ack[d]) break;
        end
        if (lat > 50) lat = -1;
        rd = rdata[d];
        er = err[d];
    endtask

    task automatic run_op(input int d, input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] a, input logic [31:0] dt, input string tag,
                          output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic        f;
        logic        er;
        int          lat;
        f = model_fault(s, a);
        if (f)      exp_rd = 32'h0;
        else if (w) exp_rd = m_rdata[d];
        else        exp_rd = model_load(d, s, u, a);
        op(d, w, s, u, a, dt, rd, er, lat);
        check({tag, "_lat"}, lat, lat_of(d));
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, er, f);
        if (w && !f) model_store(d, s, a, dt);
        m_rdata[d] = exp_rd;
    endtask

    task automatic rst_pulse(input int d);
        @(negedge clk);
        rst[d] = 1'b1;
        @(posedge clk);
        #1 rst[d] = 1'b0;
        m_rdata[d] = 32'h0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h13, 32'h80,       32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h00000080, 1'b0};
        vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0};
        if (TRAP_EN) vecs[6] = '{1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h00000000, 1'b1};
        else         vecs[6] = '{1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'hFFFFADBE, 1'b0};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h20, 32'h12348001, 32'h80ADBEEF, 1'b0};
        vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h20, 32'h0,        32'hFFFF8001, 1'b0};
        vecs[10] = '{1'b0, 2'b01, 1'b1, 32'h20, 32'h0,        32'h00008001, 1'b0};

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; sz[d] = 2'b00; uns[d] = 1'b0;
            addr[d] = 32'h0; wdata[d] = 32'h0; m_rdata[d] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset%0d_ready", d), ready[d], 1'b1);
            check($sformatf("reset%0d_ack", d), ack[d], 1'b0);
            check($sformatf("reset%0d_rdata", d), rdata[d], 32'h0);
            check($sformatf("reset%0d_err", d), err[d], 1'b0);
        end

        for (int i = 0; i < 256; i++) run_op(0, 1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom(), "init0", rd);
        rst_pulse(0);

        for (int i = 0; i < 11; i++) begin
            logic [31:0] trd;
            logic        ter;
            int          tlat;
            op(0, vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].data, trd, ter, tlat);
            check($sformatf("tbl%0d_lat", i), tlat, 1);
            check($sformatf("tbl%0d_rdata", i), trd, vecs[i].exp_rdata);
            check($sformatf("tbl%0d_err", i), ter, vecs[i].exp_err);
            if (vecs[i].we && !model_fault(vecs[i].sz, vecs[i].addr))
                model_store(0, vecs[i].sz, vecs[i].addr, vecs[i].data);
            m_rdata[0] = vecs[i].exp_rdata;
        end

        // LATENCY=4: busy window, req held high during BUSY/ACK is not accepted
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; sz[1] = 2'b10; uns[1] = 1'b0;
        addr[1] = 32'h10; wdata[1] = 32'h0BADF00D;
        check("l4_ready_idle", ready[1], 1'b1);
        @(posedge clk);
        #1 wdata[1] = 32'hBADBAD00;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("l4_ready_c%0d", c), ready[1], c == 5);
            check($sformatf("l4_ack_c%0d", c), ack[1], c == 4);
            if (c == 4) req[1] = 1'b0;
        end
        model_store(1, 2'b10, 32'h10, 32'h0BADF00D);
        run_op(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "l4_lw", rd);
        check("l4_lw_value", rd, 32'h0BADF00D);

        // reset while BUSY abandons the store
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; sz[1] = 2'b10; addr[1] = 32'h10; wdata[1] = 32'h11223344;
        @(posedge clk);
        #1 req[1] = 1'b0;
        @(negedge clk);
        check("rstbusy_ack_before", ack[1], 1'b0);
        rst[1] = 1'b1;
        @(posedge clk);
        #1 rst[1] = 1'b0;
        m_rdata[1] = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("rstbusy_ack_c%0d", c), ack[1], 1'b0);
            check($sformatf("rstbusy_ready_c%0d", c), ready[1], 1'b1);
        end
        check("rstbusy_rdata", rdata[1], 32'h0);
        run_op(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "rstbusy_lw", rd);
        check("rstbusy_lw_value", rd, 32'h0BADF00D);

        // simultaneous reset and request: reset wins
        @(negedge clk);
        rst[1] = 1'b1;
        req[1] = 1'b1; we[1] = 1'b1; sz[1] = 2'b10; addr[1] = 32'h10; wdata[1] = 32'hFFFFFFFF;
        @(posedge clk);
        #1 begin rst[1] = 1'b0; req[1] = 1'b0; end
        m_rdata[1] = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("rstreq_ready_c%0d", c), ready[1], 1'b1);
            check($sformatf("rstreq_ack_c%0d", c), ack[1], 1'b0);
        end
        check("rstreq_rdata", rdata[1], 32'h0);
        run_op(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "rstreq_lw", rd);
        check("rstreq_lw_value", rd, 32'h0BADF00D);

        // 64-byte instance: address wrap
        for (int i = 0; i < 16; i++) run_op(2, 1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom(), "init2", rd);
        run_op(2, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, "wrap_sw", rd);
        run_op(2, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, "wrap_lw", rd);
        check("wrap_lw_value", rd, 32'hCAFEF00D);
        run_op(2, 1'b1, 2'b10, 1'b0, 32'h7E, 32'h11223344, "wrap_cross_sw", rd);
        run_op(2, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, "wrap_cross_lw", rd);
        check("wrap_cross_value", rd, TRAP_EN ? 32'hCAFEF00D : 32'hCAFE1122);

        for (int i = 0; i < 300; i++)
            run_op(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom(), $urandom(), "rnd0", rd);
        for (int i = 0; i < 100; i++)
            run_op(2, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom(), $urandom(), "rnd2", rd);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
